// File: rtl/param_bram_memory_if.sv
// Bus bundle for the byte-strobed scratch memory: read port, write port, status and watch taps.
// The master modport drives requests and the slave modport (the memory) drives responses.
interface param_bram_memory_if #(
    parameter int WATCH_N = 2
);
    logic                   iwReadEn;
    logic [31:0]            iwReadAddr;
    logic [31:0]            owReadData;
    logic                   owReadValid;
    logic [31:0]            iwWriteAddr;
    logic [31:0]            iwWriteData;
    logic [3:0]             iwWstrb;
    logic                   owBusy;
    logic                   owAddrErr;
    logic [32*WATCH_N-1:0]  owWatchData;
    logic [WATCH_N-1:0]     owWatchStrobe;

    modport master (
        output iwReadEn, iwReadAddr, iwWriteAddr, iwWriteData, iwWstrb,
        input  owReadData, owReadValid, owBusy, owAddrErr, owWatchData, owWatchStrobe
    );

    modport slave (
        input  iwReadEn, iwReadAddr, iwWriteAddr, iwWriteData, iwWstrb,
        output owReadData, owReadValid, owBusy, owAddrErr, owWatchData, owWatchStrobe
    );
endinterface

// File: rtl/param_bram_memory.sv
// Byte-strobed scratch memory with a 1-cycle write-first read port, a shadowed watch window
// and an optional post-reset zeroing sequencer that holds off all accesses while it runs.
module param_bram_memory #(
    parameter int ADDR_W         = 6,
    parameter int WATCH_BASE     = 43,
    parameter int WATCH_N        = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 iwClk,
    input  logic                 iwnRst,
    param_bram_memory_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [ADDR_W-1:0]          r_clr_cnt;
    logic                       w_busy;
    logic                       w_clr_we;

    logic [31:0]                r_mem [DEPTH];

    logic [ADDR_W-1:0]          w_rd_idx;
    logic [ADDR_W-1:0]          w_wr_idx;
    logic                       w_rd_oor;
    logic                       w_wr_oor;
    logic                       w_rd_acc;
    logic                       w_wr_acc;
    logic                       w_wr_bad;
    logic [31:0]                w_wmask;
    logic [31:0]                w_rd_merged;
    logic                       w_unused_addr_lsbs;

    logic [31:0]                r_rd_data_p1;
    logic                       r_rd_vld_p1;
    logic                       r_addr_err_p1;
    logic [WATCH_N-1:0][31:0]   r_watch_p1;
    logic [WATCH_N-1:0]         r_watch_stb_p1;

    // FSM: state register
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state; the clear pass ends on the edge that zeroes the last word
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (&r_clr_cnt) w_state_nxt = ST_READY;
            ST_READY: w_state_nxt = ST_READY;
            default:  w_state_nxt = ST_READY;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_busy   = 1'b0;
        w_clr_we = 1'b0;
        if (r_state == ST_CLEAR) begin
            w_busy   = 1'b1;
            w_clr_we = 1'b1;
        end
    end

    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            r_clr_cnt <= '0;
        end else if (w_clr_we) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    assign w_rd_idx = bus.iwReadAddr[ADDR_W+1:2];
    assign w_wr_idx = bus.iwWriteAddr[ADDR_W+1:2];
    assign w_rd_oor = |bus.iwReadAddr[31:ADDR_W+2];
    assign w_wr_oor = |bus.iwWriteAddr[31:ADDR_W+2];

    assign w_rd_acc = !w_busy && bus.iwReadEn;
    assign w_wr_acc = !w_busy && (|bus.iwWstrb) && !w_wr_oor;
    assign w_wr_bad = !w_busy && (|bus.iwWstrb) && w_wr_oor;

    assign w_wmask = {{8{bus.iwWstrb[3]}}, {8{bus.iwWstrb[2]}},
                      {8{bus.iwWstrb[1]}}, {8{bus.iwWstrb[0]}}};

    assign w_unused_addr_lsbs = ^{bus.iwReadAddr[1:0], bus.iwWriteAddr[1:0]};

    // Write-first bypass: strobed bytes of a same-word write override the stored word
    always_comb begin
        w_rd_merged = r_mem[w_rd_idx];
        if (w_wr_acc && (w_wr_idx == w_rd_idx)) begin
            w_rd_merged = (w_rd_merged & ~w_wmask) | (bus.iwWriteData & w_wmask);
        end
    end

    // Array is never reset; the clear sequencer owns the write port while busy
    always_ff @(posedge iwClk) begin
        if (w_clr_we) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_acc) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.iwWstrb[b]) r_mem[w_wr_idx][8*b +: 8] <= bus.iwWriteData[8*b +: 8];
            end
        end
    end

    // Stage p1: registered read response and address-error flag
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            r_rd_data_p1  <= '0;
            r_rd_vld_p1   <= 1'b0;
            r_addr_err_p1 <= 1'b0;
        end else begin
            r_rd_vld_p1   <= w_rd_acc;
            r_addr_err_p1 <= (w_rd_acc && w_rd_oor) || w_wr_bad;
            if (w_rd_acc) begin
                r_rd_data_p1 <= w_rd_oor ? 32'h0 : w_rd_merged;
            end
        end
    end

    // Stage p1: watch shadows track the array words on the same edge
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            r_watch_p1     <= '0;
            r_watch_stb_p1 <= '0;
        end else begin
            for (int k = 0; k < WATCH_N; k++) begin
                r_watch_stb_p1[k] <= 1'b0;
                if (w_wr_acc && (w_wr_idx == ADDR_W'(WATCH_BASE + k))) begin
                    r_watch_stb_p1[k] <= 1'b1;
                    r_watch_p1[k]     <= (r_watch_p1[k] & ~w_wmask) | (bus.iwWriteData & w_wmask);
                end
            end
        end
    end

    assign bus.owReadData    = r_rd_data_p1;
    assign bus.owReadValid   = r_rd_vld_p1;
    assign bus.owBusy        = w_busy;
    assign bus.owAddrErr     = r_addr_err_p1;
    assign bus.owWatchData   = r_watch_p1;
    assign bus.owWatchStrobe = r_watch_stb_p1;
endmodule

// File: tb/tb_param_bram_memory.sv
// Bench for param_bram_memory: directed scenarios plus randomized traffic against a word-array model.
module tb_param_bram_memory;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam int WB     = 43;
    localparam int WN     = 2;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    param_bram_memory_if #(.WATCH_N(WN)) bus ();

    param_bram_memory #(
        .ADDR_W(ADDR_W), .WATCH_BASE(WB), .WATCH_N(WN), .CLEAR_ON_RESET(1)
    ) dut (
        .iwClk(clk), .iwnRst(nrst), .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: plain word array, expected responses of the last cycle
    logic [31:0]          m [DEPTH];
    logic [31:0]          exp_rd;
    logic                 exp_rv;
    logic                 exp_err;
    logic [WN-1:0]        exp_stb;

    function automatic logic [63:0] exp_watch();
        return {m[WB+1], m[WB]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m[i] = 32'h0;
        exp_rd  = 32'h0;
        exp_rv  = 1'b0;
        exp_err = 1'b0;
        exp_stb = '0;
    endtask

    // Writes land before the read is looked up, which gives write-first semantics
    task automatic model_cycle(input logic re, input logic [31:0] ra, input logic [31:0] wa,
                               input logic [31:0] wd, input logic [3:0] ws);
        bit rd_oor = (ra >= 32'(DEPTH * 4));
        bit wr_oor = (wa >= 32'(DEPTH * 4));
        int wi = int'(wa / 4);
        exp_stb = '0;
        if (ws != 4'h0 && !wr_oor) begin
            for (int b = 0; b < 4; b++) if (ws[b]) m[wi][8*b +: 8] = wd[8*b +: 8];
            if (wi >= WB && wi < WB + WN) exp_stb[wi - WB] = 1'b1;
        end
        exp_rv = re;
        if (re) exp_rd = rd_oor ? 32'h0 : m[int'(ra / 4)];
        exp_err = (re && rd_oor) || (ws != 4'h0 && wr_oor);
    endtask

    // One accepted cycle: drive, advance the model, then sample 1 time unit after the edge
    task automatic step(input logic re, input logic [31:0] ra, input logic [31:0] wa,
                        input logic [31:0] wd, input logic [3:0] ws);
        bus.iwReadEn    = re;
        bus.iwReadAddr  = ra;
        bus.iwWriteAddr = wa;
        bus.iwWriteData = wd;
        bus.iwWstrb     = ws;
        model_cycle(re, ra, wa, wd, ws);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        int sel = $urandom_range(0, 7);
        if (sel == 0) return $urandom | 32'h100;
        if (sel < 3) return 32'((WB + $urandom_range(0, WN - 1)) * 4 + $urandom_range(0, 3));
        return 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
    endfunction

    task automatic test_reset();
        int cyc = 0;
        bus.iwReadEn = 1'b0; bus.iwReadAddr = '0; bus.iwWriteAddr = '0;
        bus.iwWriteData = '0; bus.iwWstrb = '0;
        nrst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (bus.owReadData !== 32'h0) $display("FAIL rst_rd: got %h expected 0", bus.owReadData); else n_pass++;
        n_checks++; if (bus.owReadValid !== 1'b0) $display("FAIL rst_rv: got %b expected 0", bus.owReadValid); else n_pass++;
        n_checks++; if (bus.owAddrErr !== 1'b0) $display("FAIL rst_err: got %b expected 0", bus.owAddrErr); else n_pass++;
        n_checks++; if (bus.owWatchData !== 64'h0) $display("FAIL rst_watch: got %h expected 0", bus.owWatchData); else n_pass++;
        n_checks++; if (bus.owWatchStrobe !== 2'b00) $display("FAIL rst_stb: got %b expected 00", bus.owWatchStrobe); else n_pass++;
        n_checks++; if (bus.owBusy !== 1'b1) $display("FAIL rst_busy: got %b expected 1", bus.owBusy); else n_pass++;
        nrst = 1'b1;
        while (bus.owBusy === 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_checks++; if (cyc != DEPTH) $display("FAIL clear_len: got %0d cycles expected %0d", cyc, DEPTH); else n_pass++;
    endtask

    task automatic test_clear_read();
        step(1'b1, 32'hAC, 32'h0, 32'h0, 4'h0);
        n_checks++; if (bus.owReadValid !== 1'b1) $display("FAIL clr_rv: got %b expected 1", bus.owReadValid); else n_pass++;
        n_checks++; if (bus.owReadData !== 32'h0) $display("FAIL clr_rd: got %h expected 0", bus.owReadData); else n_pass++;
        idle();
        n_checks++; if (bus.owReadValid !== 1'b0) $display("FAIL clr_rv_drop: got %b expected 0", bus.owReadValid); else n_pass++;
    endtask

    task automatic test_strobe_write();
        step(1'b0, 32'h0, 32'h10, 32'hDEADBEEF, 4'hF);
        step(1'b0, 32'h0, 32'h10, 32'h11223344, 4'h5);
        step(1'b1, 32'h10, 32'h0, 32'h0, 4'h0);
        n_checks++; if (bus.owReadValid !== 1'b1) $display("FAIL strb_rv: got %b expected 1", bus.owReadValid); else n_pass++;
        n_checks++; if (bus.owReadData !== 32'hDE22BE44) $display("FAIL strb_rd: got %h expected de22be44", bus.owReadData); else n_pass++;
        idle();
        n_checks++; if (bus.owReadData !== 32'hDE22BE44) $display("FAIL strb_hold: got %h expected de22be44", bus.owReadData); else n_pass++;
    endtask

    task automatic test_rdw();
        step(1'b0, 32'h0, 32'h20, 32'h01020304, 4'hF);
        step(1'b1, 32'h20, 32'h20, 32'hAABBCCDD, 4'h3);
        n_checks++; if (bus.owReadData !== 32'h0102CCDD) $display("FAIL rdw_rd: got %h expected 0102ccdd", bus.owReadData); else n_pass++;
        step(1'b1, 32'h20, 32'h0, 32'h0, 4'h0);
        n_checks++; if (bus.owReadData !== 32'h0102CCDD) $display("FAIL rdw_after: got %h expected 0102ccdd", bus.owReadData); else n_pass++;
    endtask

    task automatic test_watch();
        step(1'b0, 32'h0, 32'hAC, 32'h12345678, 4'hF);
        n_checks++; if (bus.owWatchData[31:0] !== 32'h12345678) $display("FAIL watch0: got %h expected 12345678", bus.owWatchData[31:0]); else n_pass++;
        n_checks++; if (bus.owWatchStrobe !== 2'b01) $display("FAIL watch0_stb: got %b expected 01", bus.owWatchStrobe); else n_pass++;
        idle();
        n_checks++; if (bus.owWatchStrobe !== 2'b00) $display("FAIL watch_stb_drop: got %b expected 00", bus.owWatchStrobe); else n_pass++;
        step(1'b0, 32'h0, 32'hB0, 32'hCAFEF00D, 4'hF);
        n_checks++; if (bus.owWatchData[63:32] !== 32'hCAFEF00D) $display("FAIL watch1: got %h expected cafef00d", bus.owWatchData[63:32]); else n_pass++;
        n_checks++; if (bus.owWatchStrobe !== 2'b10) $display("FAIL watch1_stb: got %b expected 10", bus.owWatchStrobe); else n_pass++;
        step(1'b0, 32'h0, 32'hAC, 32'h00FF0000, 4'h4);
        step(1'b0, 32'h0, 32'hAC, 32'h000000AA, 4'h1);
        n_checks++; if (bus.owWatchStrobe !== 2'b01) $display("FAIL watch_level: got %b expected 01", bus.owWatchStrobe); else n_pass++;
        n_checks++; if (bus.owWatchData !== exp_watch()) $display("FAIL watch_merge: got %h expected %h", bus.owWatchData, exp_watch()); else n_pass++;
        idle();
    endtask

    task automatic test_oor();
        logic [63:0] w_before = bus.owWatchData;
        step(1'b1, 32'h104, 32'h100, 32'hFFFFFFFF, 4'hF);
        n_checks++; if (bus.owReadValid !== 1'b1) $display("FAIL oor_rv: got %b expected 1", bus.owReadValid); else n_pass++;
        n_checks++; if (bus.owReadData !== 32'h0) $display("FAIL oor_rd: got %h expected 0", bus.owReadData); else n_pass++;
        n_checks++; if (bus.owAddrErr !== 1'b1) $display("FAIL oor_err: got %b expected 1", bus.owAddrErr); else n_pass++;
        n_checks++; if (bus.owWatchStrobe !== 2'b00) $display("FAIL oor_stb: got %b expected 00", bus.owWatchStrobe); else n_pass++;
        n_checks++; if (bus.owWatchData !== w_before) $display("FAIL oor_watch: got %h expected %h", bus.owWatchData, w_before); else n_pass++;
        step(1'b1, 32'h0, 32'h0, 32'h0, 4'h0);
        n_checks++; if (bus.owAddrErr !== 1'b0) $display("FAIL oor_err_pulse: got %b expected 0", bus.owAddrErr); else n_pass++;
        n_checks++; if (bus.owReadData !== exp_rd) $display("FAIL oor_alias: got %h expected %h", bus.owReadData, exp_rd); else n_pass++;
    endtask

    task automatic test_random();
        logic        re;
        logic [31:0] ra, wa, wd;
        logic [3:0]  ws;
        for (int i = 0; i < 300; i++) begin
            re = 1'($urandom_range(0, 1));
            ra = rand_addr();
            wa = rand_addr();
            wd = $urandom;
            ws = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            step(re, ra, wa, wd, ws);
            n_checks++; if (bus.owReadValid !== exp_rv) $display("FAIL rnd_rv[%0d]: got %b expected %b", i, bus.owReadValid, exp_rv); else n_pass++;
            n_checks++; if (bus.owReadData !== exp_rd) $display("FAIL rnd_rd[%0d]: got %h expected %h", i, bus.owReadData, exp_rd); else n_pass++;
            n_checks++; if (bus.owAddrErr !== exp_err) $display("FAIL rnd_err[%0d]: got %b expected %b", i, bus.owAddrErr, exp_err); else n_pass++;
            n_checks++; if (bus.owWatchStrobe !== exp_stb) $display("FAIL rnd_stb[%0d]: got %b expected %b", i, bus.owWatchStrobe, exp_stb); else n_pass++;
            n_checks++; if (bus.owWatchData !== exp_watch()) $display("FAIL rnd_watch[%0d]: got %h expected %h", i, bus.owWatchData, exp_watch()); else n_pass++;
        end
        idle();
    endtask

    task automatic test_reset_midclear();
        int cyc = 0;
        @(negedge clk);
        nrst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        bus.iwReadEn = 1'b1; bus.iwReadAddr = 32'h204;
        bus.iwWriteAddr = 32'h40; bus.iwWriteData = 32'h5A5A5A5A; bus.iwWstrb = 4'hF;
        repeat (30) begin
            @(posedge clk);
            #1;
            n_checks++; if (bus.owReadValid !== 1'b0 || bus.owAddrErr !== 1'b0)
                $display("FAIL busy_quiet: got rv=%b err=%b expected 0/0", bus.owReadValid, bus.owAddrErr); else n_pass++;
        end
        nrst = 1'b0;
        #2;
        n_checks++; if (bus.owBusy !== 1'b1) $display("FAIL midrst_busy: got %b expected 1", bus.owBusy); else n_pass++;
        @(negedge clk);
        nrst = 1'b1;
        bus.iwWriteAddr = 32'h44;
        while (bus.owBusy === 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_checks++; if (cyc != DEPTH) $display("FAIL midrst_len: got %0d cycles expected %0d", cyc, DEPTH); else n_pass++;
        step(1'b1, 32'h40, 32'h0, 32'h0, 4'h0);
        n_checks++; if (bus.owReadData !== 32'h0) $display("FAIL busy_wr_dropped: got %h expected 0", bus.owReadData); else n_pass++;
        step(1'b1, 32'h44, 32'h0, 32'h0, 4'h0);
        n_checks++; if (bus.owReadData !== 32'h0) $display("FAIL busy_wr_dropped2: got %h expected 0", bus.owReadData); else n_pass++;
        n_checks++; if (bus.owWatchData !== 64'h0) $display("FAIL midrst_watch: got %h expected 0", bus.owWatchData); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_clear_read();
        test_strobe_write();
        test_rdw();
        test_watch();
        test_oor();
        test_random();
        test_reset_midclear();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
